// File: rtl/tb_rst_seq_pkg.sv
// ============================================================================
// tb_rst_seq_pkg : shared types, default parameters and release-edge helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package tb_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT     = 2'd0,
      ST_RELEASE    = 2'd1,
      ST_FETCH_WAIT = 2'd2,
      ST_RUN        = 2'd3
   } state_t;

   localparam int DEF_RST_CYCLES  = 16;
   localparam int DEF_NUM_STAGES  = 3;
   localparam int DEF_STAGE_GAP   = 4;
   localparam int DEF_FETCH_DELAY = 8;
   localparam int DEF_WDOG_CYCLES = 1024;

   // Edge (counted from 1 after reset release) at which rst_no[k] rises.
   function automatic int release_edge(input int rst_cycles, input int stage_gap, input int k);
      return rst_cycles + k * stage_gap;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tb_rst_seq_cnt.sv
// ============================================================================
// tb_rst_seq_cnt : loadable, saturating down-counter with a zero flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;

   // Stops at zero rather than wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tb_rst_seq.sv
// ============================================================================
// tb_rst_seq : staged active-low reset sequencer with fetch enable
// Optional watchdog restart enabled by macro TB_RST_SEQ_WDOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq
   import tb_rst_seq_pkg::*;
#(
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP,
   parameter int FETCH_DELAY = DEF_FETCH_DELAY,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  kick_i,
   output logic [NUM_STAGES-1:0] rst_no,
   output logic                  fetch_en_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic                  wdog_timeout_o
);

   localparam int c_CW = $clog2(max4(RST_CYCLES, STAGE_GAP, FETCH_DELAY, WDOG_CYCLES)) + 1;
   localparam logic [c_CW-1:0] c_LD_RST   = c_CW'((RST_CYCLES >= 2) ? RST_CYCLES - 2 : 0);
   localparam logic [c_CW-1:0] c_LD_GAP   = c_CW'(STAGE_GAP - 1);
   localparam logic [c_CW-1:0] c_LD_FETCH = c_CW'(FETCH_DELAY - 1);
   localparam logic [2:0]      c_LAST_STAGE = 3'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] c_ONE = NUM_STAGES'(1);

   if (RST_CYCLES < 1) begin : g_chk_rst
      $error("RST_CYCLES must be >= 1");
   end
   if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_chk_stages
      $error("NUM_STAGES must be 1..8");
   end
   if (STAGE_GAP < 1) begin : g_chk_gap
      $error("STAGE_GAP must be >= 1");
   end
   if (FETCH_DELAY < 1) begin : g_chk_fetch
      $error("FETCH_DELAY must be >= 1");
   end
   if (WDOG_CYCLES < 2) begin : g_chk_wdog
      $error("WDOG_CYCLES must be >= 2");
   end

   state_t                  state_q;
   logic                    armed_q;
   logic [2:0]              stage_q;
   logic [NUM_STAGES-1:0]   rst_no_q;
   logic                    fetch_en_q;
   logic                    done_q;
   logic                    busy_q;

   logic                    w_cnt_zero;
   logic                    w_cnt_load;
   logic [c_CW-1:0]         w_cnt_val;
   logic                    w_assert_done;
   logic                    w_timeout;
   logic                    w_restart;

   // The first edge in ASSERT arms the counter, so the release lands on edge RST_CYCLES.
   assign w_assert_done = (RST_CYCLES == 1) || (armed_q && w_cnt_zero);
   assign w_restart     = (state_q == ST_RUN) && (start_i || w_timeout);

   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      case (state_q)
         ST_ASSERT: begin
            if (w_assert_done) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = (NUM_STAGES == 1) ? c_LD_FETCH : c_LD_GAP;
            end else if (!armed_q) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = c_LD_RST;
            end
         end
         ST_RELEASE: begin
            if (w_cnt_zero) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = (stage_q == c_LAST_STAGE) ? c_LD_FETCH : c_LD_GAP;
            end
         end
         ST_RUN: begin
            w_cnt_load = w_restart;
         end
         default: ;
      endcase
   end

   tb_rst_seq_cnt #(.WIDTH(c_CW)) u_seq_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_cnt_load),
      .load_val_i (w_cnt_val),
      .zero_o     (w_cnt_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_ASSERT;
         armed_q    <= 1'b0;
         stage_q    <= 3'd0;
         rst_no_q   <= '0;
         fetch_en_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               armed_q <= 1'b1;
               if (w_assert_done) begin
                  rst_no_q <= c_ONE;
                  stage_q  <= 3'd1;
                  state_q  <= (NUM_STAGES == 1) ? ST_FETCH_WAIT : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (w_cnt_zero) begin
                  rst_no_q <= rst_no_q | (c_ONE << stage_q);
                  if (stage_q == c_LAST_STAGE) begin
                     state_q <= ST_FETCH_WAIT;
                  end else begin
                     stage_q <= stage_q + 3'd1;
                  end
               end
            end
            ST_FETCH_WAIT: begin
               if (w_cnt_zero) begin
                  fetch_en_q <= 1'b1;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            default: begin
               if (w_restart) begin
                  state_q    <= ST_ASSERT;
                  armed_q    <= 1'b0;
                  stage_q    <= 3'd0;
                  rst_no_q   <= '0;
                  fetch_en_q <= 1'b0;
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef TB_RST_SEQ_WDOG_EN
   localparam logic [c_CW-1:0] c_LD_WDOG = c_CW'(WDOG_CYCLES - 1);

   logic w_wdog_zero;
   logic w_wdog_load;
   logic wdog_q;

   // Held loaded outside RUN; a kick reloads it, so it fires WDOG_CYCLES edges after the last kick.
   assign w_wdog_load = (state_q != ST_RUN) || kick_i;
   assign w_timeout   = (state_q == ST_RUN) && !kick_i && w_wdog_zero;

   tb_rst_seq_cnt #(.WIDTH(c_CW)) u_wdog_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_wdog_load),
      .load_val_i (c_LD_WDOG),
      .zero_o     (w_wdog_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_q <= 1'b0;
      end else if (w_timeout) begin
         wdog_q <= 1'b1;
      end
   end

   assign wdog_timeout_o = wdog_q;
`else
   logic w_unused_kick;
   assign w_unused_kick  = kick_i;
   assign w_timeout      = 1'b0;
   assign wdog_timeout_o = 1'b0;
`endif

   assign rst_no     = rst_no_q;
   assign fetch_en_o = fetch_en_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tb_rst_seq.sv
// ============================================================================
// tb_tb_rst_seq : scoreboard bench for tb_rst_seq (output-change monitor)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tb_rst_seq;
   import tb_rst_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, kick;
   logic [2:0] rst_n;
   logic       fetch_en, done, busy, wdog;

   logic       rst1;
   logic [0:0] rst_n1;
   logic       fetch_en1, done1, busy1, wdog1;

   tb_rst_seq #(.WDOG_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .kick_i(kick),
      .rst_no(rst_n), .fetch_en_o(fetch_en), .done_o(done), .busy_o(busy),
      .wdog_timeout_o(wdog)
   );

   tb_rst_seq #(.RST_CYCLES(1), .NUM_STAGES(1), .FETCH_DELAY(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .start_i(1'b0), .kick_i(1'b1),
      .rst_no(rst_n1), .fetch_en_o(fetch_en1), .done_o(done1), .busy_o(busy1),
      .wdog_timeout_o(wdog1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [6:0] val;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;

   task automatic expect0(input int c, input logic [6:0] v);
      q0.push_back('{cyc: c, val: v});
   endtask

   task automatic expect1(input int c, input logic [6:0] v);
      q1.push_back('{cyc: c, val: v});
   endtask

   // cyc < 0 in an expected entry means the cycle is not checked.
   task automatic on_change(input int which, input logic [6:0] got);
      exp_t e;
      int   n;
      n = (which == 0) ? q0.size() : q1.size();
      tests++;
      if (n == 0) begin
         fails++;
         $display("FAIL dut%0d_unexpected_change cyc=%0d got=%b required no change", which, cyc, got);
      end else begin
         if (which == 0) e = q0.pop_front();
         else            e = q1.pop_front();
         if (got !== e.val || (e.cyc >= 0 && e.cyc != cyc)) begin
            fails++;
            $display("FAIL dut%0d_change got=%b at cyc %0d required %b at cyc %0d",
                     which, got, cyc, e.val, e.cyc);
         end
      end
   endtask

   task automatic check_val(input string name, input logic got, input logic req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s got=%b required %b", name, got, req);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      tests++;
      if (got != req) begin
         fails++;
         $display("FAIL %s got=%0d required %0d", name, got, req);
      end
   endtask

   logic [6:0] prev0, prev1, o0, o1;
   bit         first0 = 1'b1;
   bit         first1 = 1'b1;

   always @(negedge clk) begin
      o0 = {rst_n, fetch_en, done, busy, wdog};
      o1 = {2'b00, rst_n1, fetch_en1, done1, busy1, wdog1};
      if (first0 || o0 != prev0) begin
         first0 = 1'b0;
         prev0  = o0;
         on_change(0, o0);
      end
      if (first1 || o1 != prev1) begin
         first1 = 1'b0;
         prev1  = o1;
         on_change(1, o1);
      end
   end

   task automatic goto_edge(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected vectors are {rst_no[2:0], fetch_en, done, busy, wdog}.
   task automatic expect_sequence(input int base, input logic w);
      expect0(base + 16, {3'b001, 3'b001, w});
      expect0(base + 20, {3'b011, 3'b001, w});
      expect0(base + 24, {3'b111, 3'b001, w});
      expect0(base + 32, {3'b111, 3'b110, w});
   endtask

   int base;

   initial begin
      rst   = 1'b1;
      rst1  = 1'b1;
      start = 1'b0;
      kick  = 1'b1;
      expect0(-1, 7'b000_0_0_1_0);
      expect1(-1, 7'b00_0_0_0_1_0);

      // Release from reset: staged release on both instances.
      goto_edge(3);
      rst  = 1'b0;
      rst1 = 1'b0;
      base = cyc;
      expect_sequence(base, 1'b0);
      expect1(base + 1, 7'b00_1_0_0_1_0);
      expect1(base + 2, 7'b00_1_1_1_0_0);

      // Soft restart from RUN at edge 40.
      goto_edge(base + 39);
      start = 1'b1;
      goto_edge(base + 40);
      start = 1'b0;
      expect0(base + 40, 7'b000_0_0_1_0);
      base = base + 40;
      expect_sequence(base, 1'b0);

      // start_i outside RUN is ignored.
      goto_edge(base + 9);
      start = 1'b1;
      goto_edge(base + 10);
      start = 1'b0;

      // Restart again, then hit rst_i mid-release at edge 22.
      goto_edge(base + 39);
      start = 1'b1;
      goto_edge(base + 40);
      start = 1'b0;
      expect0(base + 40, 7'b000_0_0_1_0);
      base = base + 40;
      expect0(base + 16, 7'b001_0_0_1_0);
      expect0(base + 20, 7'b011_0_0_1_0);
      goto_edge(base + 22);
      rst = 1'b1;
      expect0(base + 22, 7'b000_0_0_1_0);
      goto_edge(base + 25);
      rst  = 1'b0;
      base = cyc;
      expect_sequence(base, 1'b0);
      goto_edge(base + 35);

`ifdef TB_RST_SEQ_WDOG_EN
      // Last kick at edge 35, so the watchdog fires at edge 43.
      kick = 1'b0;
      expect0(base + 43, 7'b000_0_0_1_1);
      goto_edge(base + 43);
      base = base + 43;
      expect_sequence(base, 1'b1);
      goto_edge(base + 31);
      for (int j = 0; j < 10; j++) begin
         kick = 1'b1;
         goto_edge(base + 32 + 4 * j);
         kick = 1'b0;
         goto_edge(base + 35 + 4 * j);
      end
      check_val("wdog_sticky", wdog, 1'b1);
      check_val("done_with_kicks", done, 1'b1);
`else
      kick = 1'b0;
      goto_edge(base + 35 + 2000);
      check_val("wdog_stays_low", wdog, 1'b0);
      check_val("done_stays_high", done, 1'b1);
`endif
      check_val("dut1_fetch_hold", fetch_en1, 1'b1);
      check_int("dut0_pending_changes", q0.size(), 0);
      check_int("dut1_pending_changes", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
